// File: rtl/fwd_hazard_unit_pkg.sv
// Shared definitions for the forwarding / hazard unit: forwarding-select
// encoding and the hazard FSM state type.
package fwd_hazard_unit_pkg;

    // Operand source select, shared by the EX and ID (branch-compare) muxes.
    localparam logic [1:0] FWD_RF      = 2'd0;  // register file
    localparam logic [1:0] FWD_MEM_ALU = 2'd1;  // ALU result (MEM, or EX for the ID bypass)
    localparam logic [1:0] FWD_MEM_LD  = 2'd2;  // load data in MEM
    localparam logic [1:0] FWD_WB      = 2'd3;  // write-back data

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        LU_BUBBLE = 2'd1,
        MEM_WAIT  = 2'd2
    } hz_state_e;

endpackage

// File: rtl/fwd_hazard_unit_match.sv
// fwd_match: one operand's producer compare and priority select.
// USE_EX enables the EX-to-ID bypass (ID-side instances only).
module fwd_match #(
    parameter int AW     = 5,
    parameter bit USE_EX = 1'b0
) (
    input  logic [AW-1:0] i_rs,
    input  logic [AW-1:0] i_rd_ex,
    input  logic          i_wb_ex,
    input  logic          i_memread_ex,
    input  logic [AW-1:0] i_rd_mem,
    input  logic          i_wb_mem,
    input  logic          i_memread_mem,
    input  logic [AW-1:0] i_rd_wb,
    input  logic          i_wb_wb,
    output logic [1:0]    o_sel
);
    import fwd_hazard_unit_pkg::*;

    logic w_rs_nz;
    logic w_ex_hit;
    logic w_mem_hit;
    logic w_wb_hit;

    // x0 is hardwired to zero, so a zero source address never hits.
    assign w_rs_nz   = (i_rs != '0);
    // A load in EX has no data yet; it is left to the load-use stall.
    assign w_ex_hit  = USE_EX && i_wb_ex && !i_memread_ex && w_rs_nz && (i_rd_ex == i_rs);
    assign w_mem_hit = i_wb_mem && w_rs_nz && (i_rd_mem == i_rs);
    assign w_wb_hit  = i_wb_wb && w_rs_nz && (i_rd_wb == i_rs);

    // Youngest producer wins: EX (ID side only), then MEM, then WB.
    always_comb begin
        // NOTE: assign a default first so no path leaves o_sel unassigned (no latch).
        o_sel = FWD_RF;
        if (w_ex_hit) begin
            o_sel = FWD_MEM_ALU;
        end else if (w_mem_hit) begin
            o_sel = i_memread_mem ? FWD_MEM_LD : FWD_MEM_ALU;
        end else if (w_wb_hit) begin
            o_sel = FWD_WB;
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: operand forwarding selects for EX and ID, load-use
// bubble insertion and data-memory wait stalls for a 5-stage pipeline.
// Optional feature macro FWD_HAZARD_PERF_EN adds the stall_cnt counter port.
module fwd_hazard_unit #(
    parameter int NSRC = 2,
    parameter int AW   = 5,
    parameter int CW   = 32
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [NSRC*AW-1:0] rs_id,
    input  logic [NSRC*AW-1:0] rs_ex,
    input  logic [AW-1:0]      rd_ex,
    input  logic [AW-1:0]      rd_mem,
    input  logic [AW-1:0]      rd_wb,
    input  logic               wb_ex,
    input  logic               wb_mem,
    input  logic               wb_wb,
    input  logic               memread_ex,
    input  logic               memread_mem,
    input  logic               mem_req,
    input  logic               mem_ready,
    output logic [NSRC*2-1:0]  fwd_ex,
    output logic [NSRC*2-1:0]  fwd_id,
    output logic               stall_if,
    output logic               stall_id,
    output logic               stall_ex,
    output logic               stall_mem,
    output logic               flush_ex
`ifdef FWD_HAZARD_PERF_EN
    ,
    output logic [CW-1:0]      stall_cnt
`endif
);
    import fwd_hazard_unit_pkg::*;

    if (NSRC < 1 || NSRC > 4 || AW < 1 || CW < 1) begin : g_param_check
        $error("fwd_hazard_unit: parameter out of range");
    end

    hz_state_e r_state;
    hz_state_e w_next;
    logic      w_lu;
    logic      w_id_hit;
    logic      w_mem_wait;
    logic      w_stall_front;
    logic      w_stall_back;
    logic      w_flush;

    // Per-operand forwarding selects for EX and ID.
    for (genvar k = 0; k < NSRC; k++) begin : g_src
        fwd_match #(.AW(AW), .USE_EX(1'b0)) u_ex_match (
            .i_rs          (rs_ex[k*AW +: AW]),
            .i_rd_ex       (rd_ex),
            .i_wb_ex       (wb_ex),
            .i_memread_ex  (memread_ex),
            .i_rd_mem      (rd_mem),
            .i_wb_mem      (wb_mem),
            .i_memread_mem (memread_mem),
            .i_rd_wb       (rd_wb),
            .i_wb_wb       (wb_wb),
            .o_sel         (fwd_ex[k*2 +: 2])
        );
        fwd_match #(.AW(AW), .USE_EX(1'b1)) u_id_match (
            .i_rs          (rs_id[k*AW +: AW]),
            .i_rd_ex       (rd_ex),
            .i_wb_ex       (wb_ex),
            .i_memread_ex  (memread_ex),
            .i_rd_mem      (rd_mem),
            .i_wb_mem      (wb_mem),
            .i_memread_mem (memread_mem),
            .i_rd_wb       (rd_wb),
            .i_wb_wb       (wb_wb),
            .o_sel         (fwd_id[k*2 +: 2])
        );
    end

    // Load-use detect: a load in EX feeding any ID source operand.
    always_comb begin
        // NOTE: combinational blocks use blocking '=' so later lines see earlier results.
        w_id_hit = 1'b0;
        for (int k = 0; k < NSRC; k++) begin
            if (rs_id[k*AW +: AW] == rd_ex) begin
                w_id_hit = 1'b1;
            end
        end
        w_lu = w_id_hit && memread_ex && wb_ex && (rd_ex != '0);
    end

    assign w_mem_wait = mem_req && !mem_ready;

    // State register; reset abandons any pending wait or bubble.
    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: sequential state uses non-blocking '<=' so all flops update together.
        if (!rstn) begin
            r_state <= RUN;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: a memory wait outranks a load-use bubble.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            RUN: begin
                if (w_mem_wait) begin
                    w_next = MEM_WAIT;
                end else if (w_lu) begin
                    w_next = LU_BUBBLE;
                end
            end
            LU_BUBBLE: w_next = w_mem_wait ? MEM_WAIT : RUN;
            MEM_WAIT:  w_next = mem_ready ? RUN : MEM_WAIT;
            default:   w_next = RUN;
        endcase
    end

    // Stall/flush outputs. A memory wait freezes the whole pipe from its
    // first cycle. The bubble cycle itself never stalls, so one hazard yields
    // exactly one bubble; in every other cycle (including the wait-release
    // cycle) a live load-use hazard holds IF/ID and bubbles EX.
    always_comb begin
        w_stall_front = 1'b0;
        w_stall_back  = 1'b0;
        w_flush       = 1'b0;
        if (w_mem_wait) begin
            w_stall_front = 1'b1;
            w_stall_back  = 1'b1;
        end else if (r_state != LU_BUBBLE) begin
            w_stall_front = w_lu;
            w_flush       = w_lu;
        end
    end

    // Outputs are forced quiet while reset is held.
    assign stall_if  = rstn && w_stall_front;
    assign stall_id  = rstn && w_stall_front;
    assign stall_ex  = rstn && w_stall_back;
    assign stall_mem = rstn && w_stall_back;
    assign flush_ex  = rstn && w_flush;

`ifdef FWD_HAZARD_PERF_EN
    logic [CW-1:0] r_stall_cnt;

    // Saturating count of cycles with the front end stalled.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_stall_cnt <= '0;
        end else if (stall_if && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CW'(1);
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench for fwd_hazard_unit: directed scenarios plus a
// randomized run against a behavioural reference model.
module tb_fwd_hazard_unit;

    localparam int NSRC = 2;
    localparam int AW   = 5;
    localparam int CW   = 4;

    localparam logic [4:0] CTL_NONE = 5'b00000;  // {if, id, ex, mem, flush}
    localparam logic [4:0] CTL_LU   = 5'b11001;
    localparam logic [4:0] CTL_WAIT = 5'b11110;

    logic               clk = 1'b0;
    logic               rstn = 1'b0;
    logic [NSRC*AW-1:0] rs_id, rs_ex;
    logic [AW-1:0]      rd_ex, rd_mem, rd_wb;
    logic               wb_ex, wb_mem, wb_wb, memread_ex, memread_mem, mem_req, mem_ready;
    logic [NSRC*2-1:0]  fwd_ex, fwd_id;
    logic               stall_if, stall_id, stall_ex, stall_mem, flush_ex;
    logic [4:0]         ctl;
`ifdef FWD_HAZARD_PERF_EN
    logic [CW-1:0]      stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign ctl = {stall_if, stall_id, stall_ex, stall_mem, flush_ex};

    fwd_hazard_unit #(.NSRC(NSRC), .AW(AW), .CW(CW)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .rs_id       (rs_id),
        .rs_ex       (rs_ex),
        .rd_ex       (rd_ex),
        .rd_mem      (rd_mem),
        .rd_wb       (rd_wb),
        .wb_ex       (wb_ex),
        .wb_mem      (wb_mem),
        .wb_wb       (wb_wb),
        .memread_ex  (memread_ex),
        .memread_mem (memread_mem),
        .mem_req     (mem_req),
        .mem_ready   (mem_ready),
        .fwd_ex      (fwd_ex),
        .fwd_id      (fwd_id),
        .stall_if    (stall_if),
        .stall_id    (stall_id),
        .stall_ex    (stall_ex),
        .stall_mem   (stall_mem),
        .flush_ex    (flush_ex)
`ifdef FWD_HAZARD_PERF_EN
        ,
        .stall_cnt   (stall_cnt)
`endif
    );

    task automatic idle();
        rs_id = '0; rs_ex = '0;
        rd_ex = '0; rd_mem = '0; rd_wb = '0;
        wb_ex = 1'b0; wb_mem = 1'b0; wb_wb = 1'b0;
        memread_ex = 1'b0; memread_mem = 1'b0;
        mem_req = 1'b0; mem_ready = 1'b1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            idle();
        end
    endtask

    // Drive a load in EX writing x7 and an ID instruction reading x7 on operand 1.
    task automatic drive_lu();
        memread_ex = 1'b1; wb_ex = 1'b1; rd_ex = 5'd7;
        rs_id[1*AW +: AW] = 5'd7;
    endtask

    task automatic rst_pulse();
        @(negedge clk);
        rstn = 1'b0;
        #2;
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        idle();
        drive_lu();
        mem_req = 1'b1; mem_ready = 1'b0;
        rs_ex[0 +: AW] = 5'd5; rd_mem = 5'd5; wb_mem = 1'b1;
        #3;
        checks++;
        if (ctl !== CTL_NONE) begin
            errors++; $display("FAIL reset_ctl got %b want %b", ctl, CTL_NONE);
        end
        checks++;
        if (fwd_ex[1:0] !== 2'd1) begin
            errors++; $display("FAIL reset_fwd_comb got %0d want 1", fwd_ex[1:0]);
        end
        @(negedge clk);
        #1;
        checks++;
        if (ctl !== CTL_NONE) begin
            errors++; $display("FAIL reset_ctl_held got %b want %b", ctl, CTL_NONE);
        end
`ifdef FWD_HAZARD_PERF_EN
        checks++;
        if (stall_cnt !== '0) begin
            errors++; $display("FAIL reset_cnt got %0d want 0", stall_cnt);
        end
`endif
        @(negedge clk);
        rstn = 1'b1;
        idle();
        #1;
        checks++;
        if (ctl !== CTL_NONE) begin
            errors++; $display("FAIL post_reset_ctl got %b want %b", ctl, CTL_NONE);
        end
    endtask

    task automatic test_fwd();
        @(negedge clk);
        idle();
        rs_ex[0 +: AW] = 5'd5; rd_mem = 5'd5; wb_mem = 1'b1; memread_mem = 1'b0;
        rd_wb = 5'd5; wb_wb = 1'b1;
        #1;
        checks++;
        if (fwd_ex[1:0] !== 2'd1) begin
            errors++; $display("FAIL fwd_mem_alu got %0d want 1", fwd_ex[1:0]);
        end
        memread_mem = 1'b1;
        #1;
        checks++;
        if (fwd_ex[1:0] !== 2'd2) begin
            errors++; $display("FAIL fwd_mem_ld got %0d want 2", fwd_ex[1:0]);
        end
        wb_mem = 1'b0;
        #1;
        checks++;
        if (fwd_ex[1:0] !== 2'd3) begin
            errors++; $display("FAIL fwd_wb got %0d want 3", fwd_ex[1:0]);
        end
        // Writes to x0 never forward or stall.
        @(negedge clk);
        idle();
        rd_mem = 5'd0; wb_mem = 1'b1; rs_ex[1*AW +: AW] = 5'd0;
        memread_ex = 1'b1; wb_ex = 1'b1; rd_ex = 5'd0;
        #1;
        checks++;
        if (fwd_ex[3:2] !== 2'd0) begin
            errors++; $display("FAIL fwd_x0 got %0d want 0", fwd_ex[3:2]);
        end
        checks++;
        if (ctl !== CTL_NONE) begin
            errors++; $display("FAIL x0_no_stall got %b want %b", ctl, CTL_NONE);
        end
        // ID side: EX bypass beats MEM.
        @(negedge clk);
        idle();
        rs_id[0 +: AW] = 5'd9; rd_ex = 5'd9; wb_ex = 1'b1;
        rd_mem = 5'd9; wb_mem = 1'b1; memread_mem = 1'b1;
        #1;
        checks++;
        if (fwd_id[1:0] !== 2'd1) begin
            errors++; $display("FAIL fwd_id_ex got %0d want 1", fwd_id[1:0]);
        end
        idle_cycles(2);
    endtask

    task automatic test_load_use();
        @(negedge clk);
        idle();
        drive_lu();
        #1;
        checks++;
        if (ctl !== CTL_LU) begin
            errors++; $display("FAIL lu_stall got %b want %b", ctl, CTL_LU);
        end
        // Bubble cycle: no stall even with the hazard inputs still present.
        @(negedge clk);
        rs_ex[1*AW +: AW] = 5'd7; rd_mem = 5'd7; wb_mem = 1'b1; memread_mem = 1'b1;
        #1;
        checks++;
        if (ctl !== CTL_NONE) begin
            errors++; $display("FAIL lu_one_bubble got %b want %b", ctl, CTL_NONE);
        end
        checks++;
        if (fwd_ex[3:2] !== 2'd2) begin
            errors++; $display("FAIL lu_fwd_ld got %0d want 2", fwd_ex[3:2]);
        end
        // Back in RUN: a fresh hazard stalls again.
        @(negedge clk);
        #1;
        checks++;
        if (ctl !== CTL_LU) begin
            errors++; $display("FAIL lu_back_to_run got %b want %b", ctl, CTL_LU);
        end
        idle_cycles(2);
    endtask

    task automatic test_mem_wait();
        rst_pulse();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            idle();
            mem_req = 1'b1; mem_ready = 1'b0;
            #1;
            checks++;
            if (ctl !== CTL_WAIT) begin
                errors++; $display("FAIL wait_cyc%0d got %b want %b", i, ctl, CTL_WAIT);
            end
        end
        @(negedge clk);
        mem_ready = 1'b1;
        #1;
        checks++;
        if (ctl !== CTL_NONE) begin
            errors++; $display("FAIL wait_ready got %b want %b", ctl, CTL_NONE);
        end
        @(negedge clk);
        idle();
        #1;
        checks++;
        if (ctl !== CTL_NONE) begin
            errors++; $display("FAIL wait_after got %b want %b", ctl, CTL_NONE);
        end
`ifdef FWD_HAZARD_PERF_EN
        checks++;
        if (stall_cnt !== 4'd3) begin
            errors++; $display("FAIL wait_cnt got %0d want 3", stall_cnt);
        end
`endif
    endtask

    task automatic test_lu_and_wait();
        idle_cycles(1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            idle();
            drive_lu();
            mem_req = 1'b1; mem_ready = 1'b0;
            #1;
            checks++;
            if (ctl !== CTL_WAIT) begin
                errors++; $display("FAIL luw_wait%0d got %b want %b", i, ctl, CTL_WAIT);
            end
        end
        // Release cycle: the held hazard is re-evaluated and bubbles once.
        @(negedge clk);
        mem_ready = 1'b1;
        #1;
        checks++;
        if (ctl !== CTL_LU) begin
            errors++; $display("FAIL luw_release got %b want %b", ctl, CTL_LU);
        end
        @(negedge clk);
        idle();
        #1;
        checks++;
        if (ctl !== CTL_NONE) begin
            errors++; $display("FAIL luw_after got %b want %b", ctl, CTL_NONE);
        end
        idle_cycles(1);
    endtask

    task automatic test_reset_mid_wait();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            idle();
            mem_req = 1'b1; mem_ready = 1'b0;
            #1;
            checks++;
            if (ctl !== CTL_WAIT) begin
                errors++; $display("FAIL rmw_wait%0d got %b want %b", i, ctl, CTL_WAIT);
            end
        end
        #1;
        rstn = 1'b0;
        #1;
        checks++;
        if (ctl !== CTL_NONE) begin
            errors++; $display("FAIL rmw_in_reset got %b want %b", ctl, CTL_NONE);
        end
`ifdef FWD_HAZARD_PERF_EN
        checks++;
        if (stall_cnt !== '0) begin
            errors++; $display("FAIL rmw_cnt got %0d want 0", stall_cnt);
        end
`endif
        // After release with no ready: RUN takes the hazard then bubbles;
        // a lingering wait state would keep stalling instead.
        @(negedge clk);
        rstn = 1'b1;
        idle();
        mem_ready = 1'b0;
        drive_lu();
        #1;
        checks++;
        if (ctl !== CTL_LU) begin
            errors++; $display("FAIL rmw_run_lu got %b want %b", ctl, CTL_LU);
        end
        @(negedge clk);
        #1;
        checks++;
        if (ctl !== CTL_NONE) begin
            errors++; $display("FAIL rmw_run_bubble got %b want %b", ctl, CTL_NONE);
        end
        idle_cycles(2);
    endtask

    // Reference forwarding select from the priority rules.
    function automatic logic [1:0] ref_sel(input logic [AW-1:0] rs, input bit id_side);
        if (rs == 0) return 2'd0;
        if (id_side && wb_ex && !memread_ex && rd_ex == rs) return 2'd1;
        if (wb_mem && rd_mem == rs) return memread_mem ? 2'd2 : 2'd1;
        if (wb_wb && rd_wb == rs) return 2'd3;
        return 2'd0;
    endfunction

    task automatic test_random(input int n);
        bit                waiting, bubbled, lu, mwait;
        int unsigned       cnt;
        logic [NSRC*2-1:0] e_ex, e_id;
        logic [4:0]        e_ctl;
        rst_pulse();
        waiting = 1'b0; bubbled = 1'b0; cnt = 0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            rstn = ($urandom_range(0, 49) != 0);
            for (int k = 0; k < NSRC; k++) begin
                rs_id[k*AW +: AW] = AW'($urandom_range(0, 3));
                rs_ex[k*AW +: AW] = AW'($urandom_range(0, 3));
            end
            rd_ex = AW'($urandom_range(0, 3));
            rd_mem = AW'($urandom_range(0, 3));
            rd_wb = AW'($urandom_range(0, 3));
            wb_ex = 1'($urandom_range(0, 1)); wb_mem = 1'($urandom_range(0, 1));
            wb_wb = 1'($urandom_range(0, 1));
            memread_ex = 1'($urandom_range(0, 1)); memread_mem = 1'($urandom_range(0, 1));
            mem_req = ($urandom_range(0, 2) == 0); mem_ready = 1'($urandom_range(0, 1));
            #1;
            if (!rstn) begin
                waiting = 1'b0; bubbled = 1'b0; cnt = 0;
            end
            for (int k = 0; k < NSRC; k++) begin
                e_ex[k*2 +: 2] = ref_sel(rs_ex[k*AW +: AW], 1'b0);
                e_id[k*2 +: 2] = ref_sel(rs_id[k*AW +: AW], 1'b1);
            end
            lu = 1'b0;
            for (int k = 0; k < NSRC; k++) begin
                if (memread_ex && wb_ex && rd_ex != 0 && rd_ex == rs_id[k*AW +: AW]) lu = 1'b1;
            end
            mwait = mem_req && !mem_ready;
            if (!rstn) e_ctl = CTL_NONE;
            else if (mwait) e_ctl = CTL_WAIT;
            else if (bubbled) e_ctl = CTL_NONE;
            else e_ctl = lu ? CTL_LU : CTL_NONE;
            checks++;
            if (fwd_ex !== e_ex) begin
                errors++; $display("FAIL rnd_fwd_ex cyc %0d got %b want %b", c, fwd_ex, e_ex);
            end
            checks++;
            if (fwd_id !== e_id) begin
                errors++; $display("FAIL rnd_fwd_id cyc %0d got %b want %b", c, fwd_id, e_id);
            end
            checks++;
            if (ctl !== e_ctl) begin
                errors++; $display("FAIL rnd_ctl cyc %0d got %b want %b", c, ctl, e_ctl);
            end
`ifdef FWD_HAZARD_PERF_EN
            checks++;
            if (stall_cnt !== CW'(cnt)) begin
                errors++; $display("FAIL rnd_cnt cyc %0d got %0d want %0d", c, stall_cnt, cnt);
            end
`endif
            // Advance the model to the next cycle.
            if (rstn) begin
                if (e_ctl[4] && cnt < (2 ** CW) - 1) cnt++;
                if (mwait) begin
                    waiting = 1'b1; bubbled = 1'b0;
                end else if (waiting) begin
                    if (mem_ready) waiting = 1'b0;
                end else if (bubbled) begin
                    bubbled = 1'b0;
                end else begin
                    bubbled = lu;
                end
            end
        end
        @(negedge clk);
        rstn = 1'b1;
        idle();
    endtask

    initial begin
        test_reset();
        test_fwd();
        test_load_use();
        test_mem_wait();
        test_lu_and_wait();
        test_reset_mid_wait();
        test_random(600);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_unit.md
FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

Interface
REQ-001 Parameter NSRC, default 2: number of source operands per instruction, range 1..4.
REQ-002 Parameter AW, default 5: register address width.
REQ-003 Parameter CW, default 32: width of the stall performance counter.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rstn  in  1  asynchronous, active-low reset.
REQ-006 rs_id  in  NSRC*AW  source register addresses in ID; operand k occupies bits [k*AW +: AW].
REQ-007 rs_ex  in  NSRC*AW  source register addresses in EX; same packing as rs_id.
REQ-008 rd_ex, rd_mem, rd_wb  in  AW each  destination register addresses per stage.
REQ-009 wb_ex, wb_mem, wb_wb  in  1 each  register-write enable per stage.
REQ-010 memread_ex, memread_mem  in  1 each  stage holds a load.
REQ-011 mem_req  in  1  data-memory access issued from MEM; mem_ready  in  1  data memory completes the access this cycle.
REQ-012 fwd_ex  out  NSRC*2  EX operand select: 0 = regfile, 1 = MEM ALU result, 2 = MEM load data, 3 = WB data.
REQ-013 fwd_id  out  NSRC*2  ID (branch-compare) operand select, same encoding.
REQ-014 stall_if, stall_id, stall_ex, stall_mem  out  1 each  stage hold; flush_ex  out  1  insert a bubble into EX.
REQ-015 stall_cnt  out  CW  stall-cycle count; present only when the feature is compiled in (see Configuration).

Function
REQ-016 Any comparison against register 0 SHALL be treated as a mismatch: no forwarding select and no stall is ever driven by x0.
REQ-017 fwd_ex[k] SHALL be combinational: the MEM stage has priority over WB. MEM match selects 2 if memread_mem, else 1. Otherwise a WB match selects 3. Otherwise 0.
REQ-018 fwd_id[k] SHALL be combinational: an EX match (wb_ex and not memread_ex) selects 1 via the EX-to-ID bypass. Otherwise a MEM match selects 2 if memread_mem, else 1. Otherwise a WB match selects 3. Otherwise 0.
REQ-019 Load-use hazard (lu): memread_ex && wb_ex && rd_ex!=0 && rd_ex equals any rs_id[k].
REQ-020 The FSM SHALL have the states RUN, LU_BUBBLE and MEM_WAIT, with state updates registered.
REQ-021 In RUN with mem_req && !mem_ready, the next state SHALL be MEM_WAIT; otherwise with lu, the next state SHALL be LU_BUBBLE; otherwise it SHALL stay RUN.
REQ-022 In LU_BUBBLE, the next state SHALL be MEM_WAIT if mem_req && !mem_ready, else RUN; exactly one bubble per hazard.
REQ-023 In MEM_WAIT, the next state SHALL be RUN on mem_ready, else stay MEM_WAIT.
REQ-024 Outputs in RUN: stall_if = stall_id = flush_ex = lu; stall_ex = stall_mem = 0.
REQ-025 Outputs whenever mem_req && !mem_ready, in any state including the entry cycle: all four stalls = 1 and flush_ex = 0. Memory wait overrides load-use.
REQ-026 Outputs in LU_BUBBLE without a memory wait: all stalls and flush_ex = 0.
REQ-027 On a simultaneous lu and memory-wait cycle, the memory wait SHALL win; lu re-evaluates after release, because ID/EX were held.

Reset
REQ-028 While rstn is low, the state SHALL be RUN, stall_cnt SHALL be 0, and the internal state SHALL be cleared asynchronously.
REQ-029 During reset, all stall/flush outputs SHALL read 0; the fwd outputs remain combinational in their inputs.
REQ-030 Reset asserted mid-MEM_WAIT SHALL abandon the wait; the first cycle after release SHALL be in RUN.

Configuration
REQ-031 Macro FWD_HAZARD_PERF_EN: when defined, stall_cnt SHALL increment by 1 on every cycle with stall_if=1, saturate at all-ones and never wrap.
REQ-032 When FWD_HAZARD_PERF_EN is undefined, the stall_cnt port and its register SHALL be absent.

Structure
REQ-033 A shared package SHALL hold the fwd-select encoding constants (FWD_RF, FWD_MEM_ALU, FWD_MEM_LD, FWD_WB) and the FSM state typedef.
REQ-034 Sub-module fwd_match SHALL contain the per-operand address compare plus priority select, instantiated 2*NSRC times via generate.

Verification
REQ-035 rs_ex[0]=5, rd_mem=5, wb_mem=1, memread_mem=0, rd_wb=5, wb_wb=1 -> fwd_ex[0]=1; then memread_mem=1 -> fwd_ex[0]=2.
REQ-036 rd_mem=0, wb_mem=1, rs_ex[1]=0 -> fwd_ex[1]=0, and no stall.
REQ-037 memread_ex=1, wb_ex=1, rd_ex=7, rs_id[1]=7 -> stall_if=stall_id=flush_ex=1 for exactly one cycle, then state RUN, and fwd_ex on the following cycle selects 2.
REQ-038 mem_req=1, mem_ready=0 for 3 cycles then 1 -> all stalls high for 3 cycles, low on the ready cycle +1; with PERF enabled, stall_cnt=3.
REQ-039 lu and the memory wait asserted in the same cycle -> flush_ex=0 while waiting, one bubble after release.
REQ-040 rstn pulsed low during MEM_WAIT -> stalls=0 immediately, stall_cnt=0, RUN after release.
